// File: rtl/imem_pkg.sv
// Shared definitions for the instruction-memory loader: default memory size,
// loader state encoding and the session-request legality test.
package imem_pkg;

    localparam int MEM_SIZE_DEF = 1024;

    typedef enum logic [2:0] {
        IDLE,
        RECV,
        WRITE,
        DONE,
        ERROR
    } state_t;

    // Computed 66 bits wide so a base address near 2^64 cannot wrap into range.
    function automatic logic req_ok(input logic [63:0] base,
                                    input logic [8:0]  count,
                                    input logic [65:0] mem_bytes);
        logic [65:0] end_addr;
        end_addr = {2'b00, base} + {55'd0, count, 2'b00};
        return (base[1:0] == 2'b00) && (count != 9'd0) && (end_addr <= mem_bytes);
    endfunction

endpackage

// File: rtl/imem_loader_word_assembler.sv
// Collects four MSB-first bytes into a 32-bit instruction word and flags the
// transfer that completes the word.
module word_assembler (
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        accept,
    input  logic [7:0]  in_byte,
    output logic [31:0] word_next,
    output logic        last
);

    logic [31:0] word;
    logic [1:0]  byte_cnt;

    assign word_next = {word[23:0], in_byte};
    assign last      = accept && (byte_cnt == 2'd3);

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            byte_cnt <= 2'd0;
        end else if (accept) begin
            byte_cnt <= byte_cnt + 2'd1;
        end
    end

    // Shift register holds data only; a stale partial word is harmless
    // because the counter alone decides when a word is complete.
    always_ff @(posedge clk) begin
        if (accept) begin
            word <= word_next;
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Byte-stream to instruction-memory loader: validates a load request, gathers
// bytes into words and issues one word write per four accepted bytes.
module imem_loader
    import imem_pkg::*;
#(
    parameter int MEM_SIZE = MEM_SIZE_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [63:0] base_addr,
    input  logic [8:0]  word_count,
    input  logic        in_valid,
    input  logic [7:0]  in_byte,
    output logic        in_ready,
    output logic        wr_en,
    output logic [63:0] wr_addr,
    output logic [31:0] wr_data,
    output logic        busy,
    output logic        done,
    output logic        error
);

    state_t      state;
    state_t      state_nxt;
    logic [63:0] addr;
    logic [8:0]  remaining;
    logic        start_ok;
    logic        accept;
    logic        clear;
    logic        last;
    logic [31:0] word_next;

    assign start_ok = start && ((state == IDLE) || (state == ERROR))
                      && req_ok(base_addr, word_count, 66'(MEM_SIZE));
    assign accept   = in_valid && (state == RECV);
    assign clear    = start_ok || (state == WRITE);

    word_assembler u_asm (
        .clk       (clk),
        .reset     (reset),
        .clear     (clear),
        .accept    (accept),
        .in_byte   (in_byte),
        .word_next (word_next),
        .last      (last)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        wr_en     = 1'b0;
        busy      = 1'b0;
        done      = 1'b0;
        error     = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = start_ok ? RECV : ERROR;
                end
            end
            RECV: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (last) begin
                    state_nxt = WRITE;
                end
            end
            WRITE: begin
                wr_en     = 1'b1;
                busy      = 1'b1;
                state_nxt = (remaining == 9'd1) ? DONE : RECV;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            ERROR: begin
                error = 1'b1;
                if (start) begin
                    state_nxt = start_ok ? RECV : ERROR;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Write address/data are captured on the completing byte so they are
    // already valid during the WRITE cycle and then hold until the next word.
    always_ff @(posedge clk) begin
        if (reset) begin
            addr      <= 64'd0;
            remaining <= 9'd0;
            wr_addr   <= 64'd0;
            wr_data   <= 32'd0;
        end else begin
            if (start_ok) begin
                addr      <= base_addr;
                remaining <= word_count;
            end
            if (last) begin
                wr_addr <= addr;
                wr_data <= word_next;
            end
            if (state == WRITE) begin
                addr      <= addr + 64'd4;
                remaining <= remaining - 9'd1;
            end
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Randomized self-checking bench for imem_loader against a word-level model.
module tb_imem_loader;
    localparam int MEM = 1024;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [63:0] base_addr;
    logic [8:0]  word_count;
    logic        in_valid;
    logic [7:0]  in_byte;
    logic        in_ready;
    logic        wr_en;
    logic [63:0] wr_addr;
    logic [31:0] wr_data;
    logic        busy;
    logic        done;
    logic        error;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [7:0]  src[$];
    int          got_cyc[$];
    logic [63:0] got_addr[$];
    logic [31:0] got_data[$];
    int          done_cyc[$];

    imem_loader #(.MEM_SIZE(MEM)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .base_addr  (base_addr),
        .word_count (word_count),
        .in_valid   (in_valid),
        .in_byte    (in_byte),
        .in_ready   (in_ready),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .busy       (busy),
        .done       (done),
        .error      (error)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (wr_en) begin
            got_cyc.push_back(cyc);
            got_addr.push_back(wr_addr);
            got_data.push_back(wr_data);
        end
        if (done) done_cyc.push_back(cyc);
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic bit model_legal(input logic [63:0] base, input int cnt);
        if (base % 4 != 0) return 1'b0;
        if (cnt < 1 || cnt > MEM / 4) return 1'b0;
        return base <= 64'(MEM - 4 * cnt);
    endfunction

    task automatic fill_src(input int words);
        src.delete();
        for (int i = 0; i < 4 * words; i++) src.push_back(8'($urandom_range(0, 255)));
    endtask

    task automatic clear_mon();
        got_cyc.delete();
        got_addr.delete();
        got_data.delete();
        done_cyc.delete();
    endtask

    // mode 0: in_valid held high, 1: pattern 1,0,0 repeating, 2: random
    task automatic run_session(input logic [63:0] base, input int cnt,
                               input int mode, input bit inject);
        logic [63:0] exp_a[$];
        logic [31:0] exp_d[$];
        bit legal;
        bit injected;
        bit xfer;
        int idx;
        int k;
        int nbytes;
        int n;
        legal    = model_legal(base, cnt);
        injected = 1'b0;
        clear_mon();
        if (legal) begin
            for (int w = 0; w < cnt; w++) begin
                exp_a.push_back(base + 64'(4 * w));
                exp_d.push_back({src[4*w], src[4*w+1], src[4*w+2], src[4*w+3]});
            end
        end
        start      = 1'b1;
        base_addr  = base;
        word_count = 9'(cnt);
        tick();
        start = 1'b0;
        chk("error_after_start", error, !legal);
        chk("busy_after_start", busy, legal);
        if (!legal) begin
            chk("ready_in_error", in_ready, 0);
            repeat (6) tick();
            chk("no_write_on_error", got_addr.size(), 0);
            chk("error_sticky", error, 1);
            return;
        end
        nbytes = 4 * cnt;
        idx    = 0;
        k      = 0;
        while (idx < nbytes && k < 40 * nbytes + 20) begin
            case (mode)
                0:       in_valid = 1'b1;
                1:       in_valid = (k % 3 == 0);
                default: in_valid = 1'($urandom_range(0, 1));
            endcase
            in_byte = src[idx];
            if (inject && !injected && idx == 2) begin
                start      = 1'b1;
                base_addr  = base + 64'd64;
                word_count = 9'd1;
                injected   = 1'b1;
            end
            xfer = in_valid && in_ready;
            tick();
            start = 1'b0;
            if (xfer) idx++;
            k++;
        end
        in_valid = 1'b0;
        chk("bytes_fed", idx, nbytes);
        k = 0;
        while (done_cyc.size() == 0 && k < 20) begin
            tick();
            k++;
        end
        chk("done_pulses", done_cyc.size(), 1);
        chk("write_count", got_addr.size(), exp_a.size());
        n = (got_addr.size() < exp_a.size()) ? got_addr.size() : exp_a.size();
        for (int i = 0; i < n; i++) begin
            chk("wr_addr", got_addr[i], exp_a[i]);
            chk("wr_data", got_data[i], exp_d[i]);
        end
        if (done_cyc.size() > 0 && got_cyc.size() > 0)
            chk("done_latency", done_cyc[0], got_cyc[got_cyc.size()-1] + 1);
        if (mode == 0)
            for (int i = 1; i < got_cyc.size(); i++)
                chk("throughput_gap", got_cyc[i] - got_cyc[i-1], 5);
        tick();
        chk("idle_busy", busy, 0);
        chk("wr_addr_hold", wr_addr, exp_a[exp_a.size()-1]);
        chk("wr_data_hold", wr_data, exp_d[exp_d.size()-1]);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] rb;
        int          rc;
        reset      = 1'b1;
        start      = 1'b0;
        base_addr  = 64'd0;
        word_count = 9'd0;
        in_valid   = 1'b0;
        in_byte    = 8'd0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_wr_en", wr_en, 0);
        chk("rst_wr_addr", wr_addr, 0);
        chk("rst_wr_data", wr_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_error", error, 0);

        // two-word program with a continuous stream
        src = '{8'hF8, 8'h00, 8'h03, 8'hE0, 8'h91, 8'h00, 8'h04, 8'h21};
        run_session(64'd0, 2, 0, 1'b0);
        // same bytes with a gappy stream
        run_session(64'd0, 2, 1, 1'b0);

        // misaligned request rejected, then a good one clears error
        fill_src(1);
        run_session(64'd6, 1, 0, 1'b0);
        run_session(64'd8, 1, 0, 1'b0);

        // last word of memory, then overflow past the end
        fill_src(2);
        run_session(64'd1020, 1, 0, 1'b0);
        run_session(64'd1020, 2, 0, 1'b0);
        run_session(64'd0, 0, 0, 1'b0);
        run_session(64'hFFFF_FFFF_FFFF_FFFC, 1, 0, 1'b0);

        // reset in the middle of a word, with a simultaneous start
        fill_src(1);
        start      = 1'b1;
        base_addr  = 64'd16;
        word_count = 9'd1;
        tick();
        start    = 1'b0;
        in_valid = 1'b1;
        in_byte  = 8'hAA;
        tick();
        in_byte = 8'hBB;
        tick();
        in_valid   = 1'b0;
        reset      = 1'b1;
        start      = 1'b1;
        base_addr  = 64'd32;
        clear_mon();
        tick();
        reset = 1'b0;
        start = 1'b0;
        chk("midrst_busy", busy, 0);
        chk("midrst_in_ready", in_ready, 0);
        chk("midrst_error", error, 0);
        repeat (6) tick();
        chk("midrst_no_write", got_addr.size(), 0);
        run_session(64'd16, 1, 0, 1'b0);

        // start pulsed during reception is ignored
        fill_src(3);
        run_session(64'd100, 3, 0, 1'b1);

        for (int t = 0; t < 24; t++) begin
            rc = $urandom_range(0, 6);
            rb = 64'($urandom_range(0, 255)) * 4;
            if ($urandom_range(0, 5) == 0) rb = rb + 64'($urandom_range(1, 3));
            if ($urandom_range(0, 5) == 0) rb = 64'(MEM - 4 * $urandom_range(0, 6));
            fill_src(rc);
            run_session(rb, rc, $urandom_range(0, 2), 1'($urandom_range(0, 1)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
REQ-001 SHALL have parameter MEM_SIZE, default 1024, meaning the target instruction memory size in bytes (power of two, >4).
REQ-002 SHALL have port clk  input  1  meaning the single clock; all state updates on posedge clk.
REQ-003 SHALL have port reset  input  1  meaning synchronous, active-high reset.
REQ-004 SHALL have port start  input  1  meaning a one-cycle request to begin a load session.
REQ-005 SHALL have port base_addr  input  64  meaning the first byte address to write, sampled on start.
REQ-006 SHALL have port word_count  input  9  meaning the number of 32-bit words to load (1..MEM_SIZE/4), sampled on start.
REQ-007 SHALL have port in_valid  input  1  meaning the source presents a byte.
REQ-008 SHALL have port in_byte  input  8  meaning the program byte, MSB-first within each word.
REQ-009 SHALL have port in_ready  output  1  meaning the loader accepts a byte this cycle.
REQ-010 SHALL have port wr_en  output  1  meaning the memory write strobe.
REQ-011 SHALL have port wr_addr  output  64  meaning the word-aligned byte address of the write.
REQ-012 SHALL have port wr_data  output  32  meaning the assembled instruction word.
REQ-013 SHALL have port busy  output  1  meaning a session is in progress (RECV or WRITE).
REQ-014 SHALL have port done  output  1  meaning a one-cycle pulse when the session completes.
REQ-015 SHALL have port error  output  1  meaning a rejected request; sticky until the next accepted start or reset.

Function
REQ-016 SHALL implement states IDLE, RECV, WRITE, DONE, ERROR.
REQ-017 SHALL, on start in IDLE or ERROR, go to ERROR if base_addr[1:0]!=0, word_count==0, or base_addr+4*word_count>MEM_SIZE; otherwise go to RECV with error cleared.
REQ-018 SHALL ignore start in RECV, WRITE, and DONE.
REQ-019 SHALL drive in_ready=1 only in RECV; a byte transfers when in_valid&&in_ready.
REQ-020 SHALL shift each accepted byte into the word register MSB-first: word <= {word[23:0], in_byte}.
REQ-021 SHALL count accepted bytes 0..3 and go from RECV to WRITE in the cycle after the 4th byte transfers.
REQ-022 SHALL assert wr_en for exactly one cycle in WRITE, with wr_addr=current address and wr_data=assembled word.
REQ-023 SHALL, on leaving WRITE, add 4 to the address and subtract 1 from the remaining count; go to DONE if remaining becomes 0, else to RECV with byte count 0.
REQ-024 SHALL assert done for the single DONE cycle, then return to IDLE.
REQ-025 SHALL keep wr_en=0 outside WRITE; wr_addr and wr_data hold their last values.
REQ-026 SHALL sustain a throughput of 4 bytes per 5 cycles when in_valid is held high.
REQ-027 SHALL tolerate gaps in in_valid of any length without losing or duplicating bytes.
REQ-028 SHALL guarantee that a write to the last word (address MEM_SIZE-4) is legal and never wraps past MEM_SIZE.

Reset
REQ-029 SHALL, on reset, enter IDLE with in_ready=0, wr_en=0, wr_addr=0, wr_data=0, busy=0, done=0, and error=0.
REQ-030 SHALL, on reset mid-session, discard any partial word and issue no further writes; reset overrides a simultaneous start.

Structure
REQ-031 SHALL take the MEM_SIZE default and the state enum typedef from shared package imem_pkg.
REQ-032 SHALL place byte assembly (shift register and 2-bit byte counter) in sub-module word_assembler.

Verification
REQ-033 SHALL cover: start base=0, count=2, bytes F8,00,03,E0,91,00,04,21 with in_valid held high -> wr_en at addr 0 data F80003E0, then at addr 4 data 91000421; done 1 cycle after the second write.
REQ-034 SHALL cover: start base=6 -> error=1, no wr_en, in_ready=0; then start base=8, count=1 -> error clears, 4 bytes written at addr 8.
REQ-035 SHALL cover: start base=1020, count=1 -> accepted, write at 1020; start base=1020, count=2 -> error.
REQ-036 SHALL cover: in_valid toggled 1,0,0,1,... -> same wr_data as with continuous stream; no extra or missing writes.
REQ-037 SHALL cover: reset asserted after 2 bytes of a word -> IDLE, no wr_en; a subsequent session writes the correct word.
REQ-038 SHALL cover: start pulsed during RECV with different base -> ignored; writes continue at the original addresses.
